regfile_scoreboard: RTL

Parametrised multi-read-port register file for the pipelined CPU, with a decoded write-enable path, hardwired zero register, same-cycle write-through bypass and a per-register pending (scoreboard) bit for load-use hazard detection. Sits in the decode stage: the decode logic reads operands and pending flags here, the issue logic marks destination registers, and the writeback stage writes results and clears the mark.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/decoder_onehot.sv | 18 +
 rtl/regfile_scoreboard.sv | 86 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the decode-stage register file with scoreboard.
//   WIDTH/DEPTH : default register width and count
//   ADDR_W      : register index width derived from DEPTH
//   ZERO_REG    : index of the hardwired-zero register
//   NUM_RD      : default number of read ports
package regfile_pkg;

  localparam int unsigned WIDTH    = 64;
  localparam int unsigned DEPTH    = 32;
  localparam int unsigned ADDR_W   = $clog2(DEPTH);
  localparam int unsigned ZERO_REG = DEPTH - 1;
  localparam int unsigned NUM_RD   = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [WIDTH-1:0]  reg_data_t;

endpackage

// File: rtl/decoder_onehot.sv
// Binary-to-one-hot decoder with enable.
//   in  : N-bit binary index
//   en  : when low, every output bit is 0
//   out : 2**N one-hot outputs, bit in set when en is high
module decoder_onehot #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0]      in,
  input  logic              en,
  output logic [2**N-1:0]   out
);

  always_comb begin
    out = '0;
    if (en) out[in] = 1'b1;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with hardwired-zero register, same-cycle
// write-through bypass and per-register pending (scoreboard) bits.
//   clk, reset          : clock, synchronous active-high reset
//   wr_en/addr/data     : writeback write; also clears the pending bit
//   mark_en/addr        : issue-stage mark; sets the pending bit
//   rd_addr[k]          : read address of port k
//   rd_data[k]          : combinational read data (with bypass)
//   rd_pending[k]       : combinational pending flag (write in flight clears it)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = regfile_pkg::WIDTH,
  parameter int unsigned DEPTH    = regfile_pkg::DEPTH,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned NUM_RD   = regfile_pkg::NUM_RD,
  parameter int unsigned ZERO_REG = DEPTH - 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           mark_en,
  input  logic [ADDR_W-1:0]              mark_addr,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0][WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_pending
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] wr_dec, mark_dec;
  logic [DEPTH-1:0] wr_sel, mark_sel;
  logic [DEPTH-1:0] zero_mask;
  logic             wr_live;

  // Writes are invisible to the bypass path while reset is held.
  assign wr_live = wr_en & ~reset;

  decoder_onehot #(.N(ADDR_W)) u_wr_dec (
    .in  (wr_addr),
    .en  (wr_en),
    .out (wr_dec)
  );

  decoder_onehot #(.N(ADDR_W)) u_mark_dec (
    .in  (mark_addr),
    .en  (mark_en),
    .out (mark_dec)
  );

  // Zero register can never be written nor marked.
  assign zero_mask = DEPTH'(1) << ZERO_REG;
  assign wr_sel    = wr_dec & ~zero_mask;
  assign mark_sel  = mark_dec & ~zero_mask;

  // Storage update; a mark in the same cycle as a write leaves the bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (wr_sel[i]) regs[i] <= wr_data;
      end
      pending <= mark_sel | (pending & ~wr_sel);
    end
  end

  // Independent read ports with write-through bypass.
  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic is_zero;
    logic hit;

    assign is_zero = (rd_addr[k] == ZERO_A);
    assign hit     = wr_live && (wr_addr == rd_addr[k]);

    assign rd_data[k]    = is_zero ? '0
                         : hit     ? wr_data
                         :           regs[rd_addr[k]];
    assign rd_pending[k] = ~is_zero & ~hit & pending[rd_addr[k]];
  end

endmodule
